if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID-stage decoder.
- Owns the PC register and next-PC selection, and drives the instruction-memory address.
- Holds the IF/ID pipeline register whose instruction word and interrupt flag feed the decoder.
- Consumes the decoder's 3-bit PC-source select, so the PCSrc encoding is shared between the two blocks.

---
 rtl/mips_pkg.sv | 18 +
 rtl/irq_pending_ctl.sv | 56 +++++
 rtl/if_stage.sv | 105 ++++++++++
 tb/tb_if_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: PC-source select encoding, NOP word and
// the reset and exception vector addresses used by the fetch and decode stages.
package mips_pkg;

   localparam logic [2:0] PCSRC_SEQ = 3'd0;
   localparam logic [2:0] PCSRC_BR  = 3'd1;
   localparam logic [2:0] PCSRC_J   = 3'd2;
   localparam logic [2:0] PCSRC_JR  = 3'd3;
   localparam logic [2:0] PCSRC_IRQ = 3'd4;
   localparam logic [2:0] PCSRC_EXC = 3'd5;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;

endpackage

// File: rtl/irq_pending_ctl.sv
// Interrupt request conditioning: optional 2-flop synchronizer (IF_IRQ_SYNC_EN),
// rising-edge detect and a pending flag that is cleared when the IRQ vector is taken.
module irq_pending_ctl
   import mips_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic irq_i,
   input  logic ack_i,
   output logic pending_o
);

   logic irq_s;
   logic irq_s_prev_q;
   logic pending_q, pending_d;

`ifdef IF_IRQ_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= irq_i;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq_i;
`endif

   // A new edge beats acceptance so a request arriving on the ack edge is not lost.
   always_comb begin
      pending_d = pending_q;
      if (ack_i)
         pending_d = 1'b0;
      if (irq_s && !irq_s_prev_q)
         pending_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_s_prev_q <= 1'b0;
         pending_q    <= 1'b0;
      end else begin
         irq_s_prev_q <= irq_s;
         pending_q    <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC mux and IF/ID register.
// Build option IF_IRQ_SYNC_EN enables the 2-flop irq_in synchronizer.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEF,
   parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  pc_src,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [25:0] jump_index,
   input  logic [31:0] jr_target,
   input  logic        stall,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        irq_in,
   output logic [31:0] pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_irq
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcp4_q, pcp4_d;
   logic        irq_q, irq_d;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        redirect;
   logic        irq_pending;
   logic        irq_pending_eff;

   assign pc_plus4 = pc_q + 32'd4;

   // Encodings 6 and 7 fall through to sequential fetch.
   always_comb begin
      next_pc  = pc_plus4;
      redirect = 1'b1;
      case (pc_src)
         PCSRC_BR: begin
            next_pc  = branch_taken ? branch_target : pc_plus4;
            redirect = branch_taken;
         end
         PCSRC_J:   next_pc = {pc_q[31:28], jump_index, 2'b00};
         PCSRC_JR:  next_pc = jr_target;
         PCSRC_IRQ: next_pc = IRQ_VEC;
         PCSRC_EXC: next_pc = EXC_VEC;
         default:   redirect = 1'b0;
      endcase
   end

   // Kernel-space code (pc[31]=1) runs with interrupts masked.
   assign irq_pending_eff = irq_pending & ~pc_q[31];

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pcp4_d  = pcp4_q;
      irq_d   = irq_q;
      if (redirect) begin
         pc_d    = next_pc;
         instr_d = NOP_INSTR;
         pcp4_d  = pc_plus4;
         irq_d   = 1'b0;
      end else if (!stall) begin
         pc_d    = pc_plus4;
         instr_d = imem_data;
         pcp4_d  = pc_plus4;
         irq_d   = irq_pending_eff;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pcp4_q  <= 32'h0;
         irq_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcp4_q  <= pcp4_d;
         irq_q   <= irq_d;
      end
   end

   irq_pending_ctl u_irq_pending_ctl (
      .clk_i     (clk),
      .rst_ni    (reset),
      .irq_i     (irq_in),
      .ack_i     (pc_src == PCSRC_IRQ),
      .pending_o (irq_pending)
   );

   assign imem_addr      = pc_q;
   assign pc             = pc_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc_plus4 = pcp4_q;
   assign if_id_irq      = irq_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared against a behavioural fetch-stage model.
module tb_if_stage;

`ifdef IF_IRQ_SYNC_EN
   localparam int IRQ_LAT = 4;
`else
   localparam int IRQ_LAT = 2;
`endif
   localparam int SYNC_D = IRQ_LAT - 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  pc_src;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [25:0] jump_index;
   logic [31:0] jr_target;
   logic        stall;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        irq_in;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_irq;

   int checks   = 0;
   int failures = 0;

   bit          use_fixed  = 1'b0;
   logic [31:0] fixed_word = 32'h0;

   // Behavioural model state
   logic [31:0] m_pc, m_instr, m_pcp4;
   logic        m_irq, m_pend, m_prev_s;
   logic        m_hist [0:2];

   always #5 clk = ~clk;

   if_stage dut (
      .clk            (clk),
      .reset          (reset),
      .pc_src         (pc_src),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump_index     (jump_index),
      .jr_target      (jr_target),
      .stall          (stall),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .irq_in         (irq_in),
      .pc             (pc),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_irq      (if_id_irq)
   );

   function automatic logic [31:0] hash(input logic [31:0] a);
      return {a[15:0] ^ 16'h3c1d, a[31:16] ^ 16'h0f0f} + 32'h0101_0001;
   endfunction

   always_comb imem_data = use_fixed ? fixed_word : hash(imem_addr);

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return use_fixed ? fixed_word : hash(a);
   endfunction

   task automatic model_reset();
      m_pc = 32'h8000_0000; m_instr = 32'h0; m_pcp4 = 32'h0;
      m_irq = 1'b0; m_pend = 1'b0; m_prev_s = 1'b0;
      for (int i = 0; i < 3; i++) m_hist[i] = 1'b0;
   endtask

   // One rising edge of the architectural fetch stage, from the spec's rules.
   task automatic model_edge();
      logic [31:0] p4, npc;
      bit          redir, s_now, eff;
      p4    = m_pc + 32'd4;
      npc   = p4;
      redir = 1'b1;
      case (pc_src)
         3'd1: if (branch_taken) npc = branch_target; else redir = 1'b0;
         3'd2: npc = {m_pc[31:28], jump_index, 2'b00};
         3'd3: npc = jr_target;
         3'd4: npc = 32'h8000_0004;
         3'd5: npc = 32'h8000_0008;
         default: redir = 1'b0;
      endcase
      eff = m_pend && !m_pc[31];
      if (redir) begin
         m_pc = npc; m_instr = 32'h0; m_pcp4 = p4; m_irq = 1'b0;
      end else if (!stall) begin
         m_instr = mem_word(m_pc); m_pcp4 = p4; m_irq = eff; m_pc = p4;
      end
      m_hist[0] = irq_in;
      s_now = m_hist[SYNC_D];
      if (s_now && !m_prev_s) m_pend = 1'b1;
      else if (pc_src == 3'd4) m_pend = 1'b0;
      m_prev_s  = s_now;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_idle();
      pc_src = 3'd0; branch_taken = 1'b0; stall = 1'b0;
      branch_target = 32'h0; jump_index = 26'h0; jr_target = 32'h0;
   endtask

   task automatic do_reset();
      set_idle();
      irq_in = 1'b0;
      reset  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      use_fixed = 1'b1; fixed_word = 32'h2008_0005;
      do_reset();
      checks++; if (pc !== 32'h8000_0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h8000_0000); end
      checks++; if (imem_addr !== 32'h8000_0000) begin failures++; $display("FAIL reset_imem_addr got=%h exp=%h", imem_addr, 32'h8000_0000); end
      checks++; if (if_id_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", if_id_instr); end
      checks++; if (if_id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_pcp4 got=%h exp=0", if_id_pc_plus4); end
      checks++; if (if_id_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", if_id_irq); end
      tick();
      checks++; if (pc !== 32'h8000_0004) begin failures++; $display("FAIL first_pc got=%h exp=%h", pc, 32'h8000_0004); end
      checks++; if (if_id_instr !== 32'h2008_0005) begin failures++; $display("FAIL first_instr got=%h exp=%h", if_id_instr, 32'h2008_0005); end
      checks++; if (if_id_pc_plus4 !== 32'h8000_0004) begin failures++; $display("FAIL first_pcp4 got=%h exp=%h", if_id_pc_plus4, 32'h8000_0004); end
      use_fixed = 1'b0;
   endtask

   task automatic test_stall();
      set_idle();
      pc_src = 3'd3; jr_target = 32'h0000_000C;
      tick();
      pc_src = 3'd0;
      tick();
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++; if (pc !== 32'h0000_0010) begin failures++; $display("FAIL stall_pc got=%h exp=%h", pc, 32'h10); end
         checks++; if (if_id_instr !== hash(32'h0000_000C)) begin failures++; $display("FAIL stall_instr got=%h exp=%h", if_id_instr, hash(32'hC)); end
      end
      stall = 1'b0;
      tick();
      checks++; if (pc !== 32'h0000_0014) begin failures++; $display("FAIL stall_release_pc got=%h exp=%h", pc, 32'h14); end
      checks++; if (if_id_instr !== hash(32'h0000_0010)) begin failures++; $display("FAIL stall_release_instr got=%h exp=%h", if_id_instr, hash(32'h10)); end
   endtask

   task automatic test_flush_over_stall();
      set_idle();
      pc_src = 3'd3; jr_target = 32'h0000_00FC;
      tick();
      pc_src = 3'd0;
      tick();
      pc_src = 3'd2; jump_index = 26'h40; stall = 1'b1;
      tick();
      checks++; if (pc !== 32'h0000_0100) begin failures++; $display("FAIL jflush_pc got=%h exp=%h", pc, 32'h100); end
      checks++; if (if_id_instr !== 32'h0) begin failures++; $display("FAIL jflush_instr got=%h exp=0", if_id_instr); end
      checks++; if (if_id_pc_plus4 !== 32'h0000_0104) begin failures++; $display("FAIL jflush_pcp4 got=%h exp=%h", if_id_pc_plus4, 32'h104); end
   endtask

   task automatic test_branch();
      set_idle();
      pc_src = 3'd1; branch_taken = 1'b0; branch_target = 32'h0000_0200;
      tick();
      checks++; if (pc !== 32'h0000_0104) begin failures++; $display("FAIL br_nt_pc got=%h exp=%h", pc, 32'h104); end
      checks++; if (if_id_instr !== hash(32'h0000_0100)) begin failures++; $display("FAIL br_nt_instr got=%h exp=%h", if_id_instr, hash(32'h100)); end
      branch_taken = 1'b1;
      tick();
      checks++; if (pc !== 32'h0000_0200) begin failures++; $display("FAIL br_t_pc got=%h exp=%h", pc, 32'h200); end
      checks++; if (if_id_instr !== 32'h0) begin failures++; $display("FAIL br_t_instr got=%h exp=0", if_id_instr); end
      checks++; if (if_id_pc_plus4 !== 32'h0000_0108) begin failures++; $display("FAIL br_t_pcp4 got=%h exp=%h", if_id_pc_plus4, 32'h108); end
   endtask

   task automatic test_irq_user();
      do_reset();
      pc_src = 3'd3; jr_target = 32'h0000_0040;
      tick();
      pc_src = 3'd0; irq_in = 1'b1;
      for (int k = 1; k < IRQ_LAT; k++) begin
         tick();
         checks++; if (if_id_irq !== 1'b0) begin failures++; $display("FAIL irq_early edge=%0d got=%b exp=0", k, if_id_irq); end
      end
      tick();
      checks++; if (if_id_irq !== 1'b1) begin failures++; $display("FAIL irq_latency got=%b exp=1", if_id_irq); end
      pc_src = 3'd4;
      tick();
      checks++; if (pc !== 32'h8000_0004) begin failures++; $display("FAIL irq_vec_pc got=%h exp=%h", pc, 32'h8000_0004); end
      checks++; if (if_id_irq !== 1'b0) begin failures++; $display("FAIL irq_ack_flush got=%b exp=0", if_id_irq); end
      pc_src = 3'd3; jr_target = 32'h0000_0060;
      tick();
      pc_src = 3'd0;
      tick();
      checks++; if (if_id_irq !== 1'b0) begin failures++; $display("FAIL irq_cleared got=%b exp=0", if_id_irq); end
      irq_in = 1'b0;
   endtask

   task automatic test_irq_kernel();
      do_reset();
      pc_src = 3'd3; jr_target = 32'h8000_0010;
      tick();
      pc_src = 3'd0; irq_in = 1'b1;
      for (int k = 0; k < IRQ_LAT + 2; k++) begin
         tick();
         checks++; if (if_id_irq !== 1'b0) begin failures++; $display("FAIL irq_masked edge=%0d got=%b exp=0", k, if_id_irq); end
      end
      pc_src = 3'd3; jr_target = 32'h0000_0050;
      tick();
      checks++; if (pc !== 32'h0000_0050) begin failures++; $display("FAIL irq_jr_pc got=%h exp=%h", pc, 32'h50); end
      pc_src = 3'd0;
      tick();
      checks++; if (if_id_irq !== 1'b1) begin failures++; $display("FAIL irq_unmasked got=%b exp=1", if_id_irq); end
      irq_in = 1'b0;
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 15));
         pc_src        = (r < 8) ? 3'd0 : 3'(r - 8);
         branch_taken  = 1'($urandom_range(0, 1));
         branch_target = $urandom;
         jump_index    = 26'($urandom);
         jr_target     = {1'($urandom_range(0, 1)), 31'($urandom)};
         stall         = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) irq_in = ~irq_in;
         tick();
         checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, pc, m_pc); end
         checks++; if (imem_addr !== m_pc) begin failures++; $display("FAIL rnd_imem_addr i=%0d got=%h exp=%h", i, imem_addr, m_pc); end
         checks++; if (if_id_instr !== m_instr) begin failures++; $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, if_id_instr, m_instr); end
         checks++; if (if_id_pc_plus4 !== m_pcp4) begin failures++; $display("FAIL rnd_pcp4 i=%0d got=%h exp=%h", i, if_id_pc_plus4, m_pcp4); end
         checks++; if (if_id_irq !== m_irq) begin failures++; $display("FAIL rnd_irq i=%0d got=%b exp=%b", i, if_id_irq, m_irq); end
         if (i == 200) begin
            reset = 1'b0;
            #2;
            model_reset();
            checks++; if (pc !== 32'h8000_0000) begin failures++; $display("FAIL async_reset_pc got=%h exp=%h", pc, 32'h8000_0000); end
            checks++; if (if_id_instr !== 32'h0) begin failures++; $display("FAIL async_reset_instr got=%h exp=0", if_id_instr); end
            @(negedge clk);
            reset = 1'b1;
         end
      end
      irq_in = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      irq_in = 1'b0;
      set_idle();
      model_reset();
      test_reset();
      test_stall();
      test_flush_over_stall();
      test_branch();
      test_irq_user();
      test_irq_kernel();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
